// File: rtl/fetch_queue_if.sv
// fetch_queue_if: redirect, memory request/response and decode-side handshake of the fetch queue.
interface fetch_queue_if #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4
);
    logic                       redirect;
    logic [XLEN-1:0]            redirect_pc;
    logic                       mem_req;
    logic [XLEN-1:0]            mem_addr;
    logic                       mem_gnt;
    logic                       mem_rvalid;
    logic [XLEN-1:0]            mem_rdata;
    logic                       out_valid;
    logic [XLEN-1:0]            out_inst;
    logic [XLEN-1:0]            out_pc;
    logic                       out_ready;
    logic [$clog2(DEPTH+1)-1:0] count;
    modport master (
        input  redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, out_inst, out_pc, count
    );
    modport slave (
        output redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, out_inst, out_pc, count
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetcher with an in-order response FIFO;
// a redirect flushes the FIFO and drops responses still in flight.
module fetch_queue #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
    logic [XLEN-1:0]   fetch_pc, ret_pc, target;
    logic [CW-1:0]     count, pending, discard;
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [2*XLEN-1:0] fifo [DEPTH];
    logic              issue, gnt, rsp, push, pop, valid;
    always_comb begin
        target = {bus.redirect_pc[XLEN-1:2], 2'b00};
        issue  = rst && !bus.redirect && (({1'b0, count} + {1'b0, pending}) < (CW+1)'(DEPTH));
        gnt    = issue && bus.mem_gnt;
        rsp    = bus.mem_rvalid && pending != '0;
        push   = rsp && discard == '0 && !bus.redirect;
        valid  = count != '0;
        pop    = valid && bus.out_ready && !bus.redirect;
    end
    // Buffered plus in-flight fetches never exceed DEPTH, so a push always finds room.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            ret_pc   <= RESET_PC;
            count    <= '0;
            pending  <= '0;
            discard  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= target;
            ret_pc   <= target;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            pending  <= pending - CW'(rsp);
            discard  <= pending - CW'(rsp);
        end else begin
            fetch_pc <= gnt ? fetch_pc + XLEN'(4) : fetch_pc;
            ret_pc   <= push ? ret_pc + XLEN'(4) : ret_pc;
            pending  <= pending + CW'(gnt) - CW'(rsp);
            discard  <= (rsp && discard != '0) ? discard - CW'(1) : discard;
            count    <= count + CW'(push) - CW'(pop);
            wr_ptr   <= wr_ptr + AW'(push);
            rd_ptr   <= rd_ptr + AW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= {bus.mem_rdata, ret_pc};
    end
    assign bus.mem_req   = issue;
    assign bus.mem_addr  = fetch_pc;
    assign bus.out_valid = valid;
    assign bus.out_inst  = valid ? fifo[rd_ptr][2*XLEN-1:XLEN] : NOP;
    assign bus.out_pc    = valid ? fifo[rd_ptr][XLEN-1:0] : '0;
    assign bus.count     = count;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios against a queue-based model of the fetch queue,
// checked every cycle, plus hand-computed literal expectations.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] SALT = 32'hA5A5_0000;
    typedef struct { logic [31:0] addr; bit stale; } flight_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc; } entry_t;
    logic clk = 0;
    logic rst = 0;
    int vectors = 0;
    int miscompares = 0;
    int grants = 0;
    bit auto_rsp = 0;
    flight_t inflight[$];
    entry_t fq[$];
    logic [31:0] m_fpc;
    logic [31:0] mq[$];
    fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();
    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_reset();
        inflight.delete();
        fq.delete();
        m_fpc = 32'h0;
    endtask
    task automatic respond();
        if (auto_rsp) begin
            bus.mem_rvalid = mq.size() > 0;
            bus.mem_rdata  = mq.size() > 0 ? (mq[0] ^ SALT) : 32'h0;
        end
    endtask
    task automatic step();
        logic s_rst, s_redir, s_gnt, s_rv, s_rdy, s_dreq, e_req, e_valid, do_pop;
        logic [31:0] s_rpc, s_rdata, s_daddr;
        flight_t f;
        @(negedge clk);
        e_valid = fq.size() != 0;
        e_req = rst && !bus.redirect && (fq.size() + inflight.size() < DEPTH);
        chk("mem_req", 32'(bus.mem_req), 32'(e_req));
        chk("mem_addr", bus.mem_addr, m_fpc);
        chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
        chk("out_inst", bus.out_inst, e_valid ? fq[0].inst : NOP);
        chk("out_pc", bus.out_pc, e_valid ? fq[0].pc : 32'h0);
        chk("count", 32'(bus.count), fq.size());
        s_rst = rst; s_redir = bus.redirect; s_gnt = bus.mem_gnt; s_rv = bus.mem_rvalid;
        s_rdy = bus.out_ready; s_rpc = bus.redirect_pc; s_rdata = bus.mem_rdata;
        s_dreq = bus.mem_req; s_daddr = bus.mem_addr;
        @(posedge clk);
        if (!s_rst) begin
            model_reset();
        end else begin
            if (s_rv && mq.size() > 0) void'(mq.pop_front());
            if (s_dreq && s_gnt) begin
                mq.push_back(s_daddr);
                grants++;
            end
            do_pop = !s_redir && s_rdy && fq.size() > 0;
            if (s_rv && inflight.size() > 0) begin
                f = inflight.pop_front();
                if (!f.stale && !s_redir) fq.push_back('{inst: s_rdata, pc: f.addr});
            end
            if (do_pop) void'(fq.pop_front());
            if (s_redir) begin
                fq.delete();
                foreach (inflight[i]) inflight[i].stale = 1;
                m_fpc = s_rpc & ~32'h3;
            end else if (e_req && s_gnt) begin
                inflight.push_back('{addr: m_fpc, stale: 0});
                m_fpc += 4;
            end
        end
        #1;
        respond();
    endtask
    task automatic do_reset();
        rst = 0;
        bus.redirect = 0; bus.redirect_pc = 0; bus.mem_gnt = 0;
        bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.out_ready = 0;
        auto_rsp = 0;
        model_reset();
        mq.delete();
        step();
        step();
        rst = 1;
    endtask
    initial begin
        // streaming fetch, 1-cycle memory latency
        do_reset();
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_inst", bus.out_inst, NOP);
        bus.mem_gnt = 1; bus.out_ready = 1; auto_rsp = 1;
        step();
        chk("t1_valid_early", 32'(bus.out_valid), 32'h0);
        step();
        chk("t1_pc0", bus.out_pc, 32'h0);
        chk("t1_inst0", bus.out_inst, 32'hA5A5_0000);
        step();
        chk("t1_pc1", bus.out_pc, 32'h4);
        chk("t1_inst1", bus.out_inst, 32'hA5A5_0004);
        repeat (6) step();
        // stalled decode fills the queue
        do_reset();
        grants = 0;
        bus.mem_gnt = 1; auto_rsp = 1;
        repeat (6) step();
        chk("t2_grants", grants, 32'd4);
        chk("t2_count", 32'(bus.count), 32'd4);
        chk("t2_req_held", 32'(bus.mem_req), 32'h0);
        bus.out_ready = 1;
        step();
        bus.out_ready = 0;
        chk("t2_req_again", 32'(bus.mem_req), 32'h1);
        chk("t2_addr", bus.mem_addr, 32'h10);
        chk("t2_head", bus.out_pc, 32'h4);
        repeat (3) step();
        // redirect with two fetches in flight
        do_reset();
        bus.mem_gnt = 1; bus.out_ready = 1;
        step();
        step();
        bus.mem_gnt = 0; bus.redirect = 1; bus.redirect_pc = 32'h103;
        step();
        bus.redirect = 0; bus.mem_gnt = 1; auto_rsp = 1;
        respond();
        chk("t3_addr", bus.mem_addr, 32'h100);
        chk("t3_count", 32'(bus.count), 32'h0);
        step();
        chk("t3_flush1", 32'(bus.count), 32'h0);
        step();
        chk("t3_flush2", 32'(bus.count), 32'h0);
        step();
        chk("t3_pc", bus.out_pc, 32'h100);
        chk("t3_inst", bus.out_inst, 32'hA5A5_0100);
        repeat (3) step();
        // redirect, response and pop in the same cycle, three in flight
        do_reset();
        bus.mem_gnt = 1;
        step();
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h1234_5678;
        step();
        bus.mem_rvalid = 0;
        step();
        step();
        chk("t4_count_pre", 32'(bus.count), 32'h1);
        chk("t4_req_pre", 32'(bus.mem_req), 32'h0);
        bus.redirect = 1; bus.redirect_pc = 32'h200; bus.mem_rvalid = 1;
        bus.mem_rdata = 32'hDEAD_BEEF; bus.out_ready = 1;
        step();
        chk("t4_count", 32'(bus.count), 32'h0);
        chk("t4_valid", 32'(bus.out_valid), 32'h0);
        bus.redirect = 0; auto_rsp = 1;
        respond();
        step();
        chk("t4_drop", 32'(bus.count), 32'h0);
        step();
        step();
        chk("t4_pc", bus.out_pc, 32'h200);
        chk("t4_inst", bus.out_inst, 32'hA5A5_0200);
        repeat (2) step();
        // grant withheld, then a stray response with nothing pending
        do_reset();
        auto_rsp = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_addr", bus.mem_addr, 32'h0);
            chk("t5_req", 32'(bus.mem_req), 32'h1);
        end
        auto_rsp = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hBAD0_BAD0;
        step();
        chk("t5_stray_count", 32'(bus.count), 32'h0);
        chk("t5_stray_valid", 32'(bus.out_valid), 32'h0);
        bus.mem_rvalid = 0; bus.mem_gnt = 1; auto_rsp = 1;
        step();
        step();
        chk("t5_inst", bus.out_inst, 32'hA5A5_0000);
        // asynchronous reset mid-stream
        do_reset();
        bus.mem_gnt = 1; auto_rsp = 1;
        repeat (4) step();
        chk("t6_count_pre", 32'(bus.count), 32'h3);
        #3 rst = 0;
        #1;
        chk("t6_valid", 32'(bus.out_valid), 32'h0);
        chk("t6_req", 32'(bus.mem_req), 32'h0);
        chk("t6_count", 32'(bus.count), 32'h0);
        model_reset();
        mq.delete();
        auto_rsp = 0; bus.mem_rvalid = 0;
        step();
        step();
        rst = 1;
        auto_rsp = 1;
        #1;
        chk("t6_addr", bus.mem_addr, 32'h0);
        chk("t6_req_rel", 32'(bus.mem_req), 32'h1);
        repeat (4) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
